pipe_hazard_ctrl: RTL

Pipeline control unit for the five-stage ARM core, generating every freeze, flush and bubble signal the pipeline registers currently have tied off. It detects read-after-write hazards between the instruction in ID and the instructions in EX and MEM. It also converts a taken branch in EX into IF/ID and ID/EX flushes. A small FSM sequences multi-cycle data-memory accesses through a request/ready handshake, stalling the whole pipeline until the memory responds.

---
 rtl/ctrl_pkg.sv | 12 +
 rtl/mem_wait_fsm.sv | 93 +++++++++
 rtl/pipe_hazard_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline hazard / memory-wait control slice.
package ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_ERR  = 2'd2;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/mem_wait_fsm.sv
// Sequences multi-cycle data-memory accesses over a req/ready handshake and
// decodes the whole-pipeline stall; a timeout parks the FSM in ERR until reset.
module mem_wait_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_r_en,
  input  logic mem_w_en,
  input  logic sram_ready,
  output logic stall_all,
  output logic sram_req,
  output logic sram_we,
  output logic mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] WCNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] wcnt_nxt;
  logic          we_nxt;
  logic          stall;

  // Next-state, wait counter and stall decode
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    we_nxt    = sram_we;
    stall     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_r_en || mem_w_en) begin
          stall     = 1'b1;
          state_nxt = ST_WAIT;
          wcnt_nxt  = '0;
          we_nxt    = mem_w_en;
        end else begin
          we_nxt    = 1'b0;
        end
      end
      ST_WAIT: begin
        // ready releases the stall in the same cycle so the pipeline advances once
        if (sram_ready) begin
          state_nxt = ST_IDLE;
          we_nxt    = 1'b0;
        end else begin
          stall    = 1'b1;
          wcnt_nxt = wcnt + CW'(1);
          if (wcnt == WCNT_LAST) begin
            state_nxt = ST_ERR;
            we_nxt    = 1'b0;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_ERR: begin
        stall     = 1'b1;
        state_nxt = ST_ERR;
        we_nxt    = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
        we_nxt    = 1'b0;
      end
    endcase
  end

  assign stall_all = stall & ~rst;

  // State and registered handshake/error decodes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      sram_req <= 1'b0;
      sram_we  <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      sram_req <= (state_nxt == ST_WAIT);
      sram_we  <= we_nxt;
      mem_err  <= (state_nxt == ST_ERR);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline control: RAW hazard detection, branch flush, memory-wait
// stall and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int FWD_EN      = 0,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             id_src1,
  input  logic [3:0]             id_src2,
  input  logic                   id_src1_vld,
  input  logic                   id_src2_vld,
  input  logic                   ex_wb_en,
  input  logic                   ex_mem_r_en,
  input  logic [3:0]             ex_dest,
  input  logic                   mem_wb_en,
  input  logic [3:0]             mem_dest,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic                   branch_taken,
  input  logic                   sram_ready,
  output logic                   freeze_pc,
  output logic                   freeze_if_id,
  output logic                   flush_if_id,
  output logic                   bubble_id_ex,
  output logic                   stall_all,
  output logic                   sram_req,
  output logic                   sram_we,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic ex_match;
  logic mem_match;
  logic haz;

  // WB-stage writes are not compared: the register file writes on the opposite edge
  assign ex_match  = (id_src1_vld & (id_src1 == ex_dest)) | (id_src2_vld & (id_src2 == ex_dest));
  assign mem_match = (id_src1_vld & (id_src1 == mem_dest)) | (id_src2_vld & (id_src2 == mem_dest));
  assign haz = (FWD_EN != 0) ? (ex_wb_en & ex_mem_r_en & ex_match)
                             : ((ex_wb_en & ex_match) | (mem_wb_en & mem_match));

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .sram_ready (sram_ready),
    .stall_all  (stall_all),
    .sram_req   (sram_req),
    .sram_we    (sram_we),
    .mem_err    (mem_err)
  );

  // Priority: memory stall, then branch flush, then hazard freeze
  always_comb begin
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    if (rst || stall_all) begin
      freeze_pc = 1'b0;
    end else if (branch_taken) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (haz) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      bubble_id_ex = 1'b1;
    end else begin
      bubble_id_ex = 1'b0;
    end
  end

  // Saturating count of stalled/frozen cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((stall_all || freeze_pc) && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule
